// File: rtl/serial_sum_deser_pkg.sv
// serial_adder_pkg: shared types and constants for the serial_adder deserializer slice.
// Contents: deser_state_e (IDLE/SHIFT), DEFAULT_WIDTH (result word width), STAT_W (statistics counter width).
package serial_adder_pkg;
    typedef enum logic [0:0] {IDLE, SHIFT} deser_state_e;
    localparam int DEFAULT_WIDTH = 8;
    localparam int STAT_W = 16;
endpackage

// File: rtl/serial_sum_deser_hold_reg.sv
// deser_hold_reg: one-entry valid/ready holding register for completed words.
// Ports: clk, rst (async, active-high); load_vld/load_data/load_cout offer a completed word;
// rdy from consumer; data/cout/vld present the held word; overrun pulses when an offered word is dropped.
module deser_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_vld,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_cout,
    input  logic             rdy,
    output logic [WIDTH-1:0] data,
    output logic             cout,
    output logic             vld,
    output logic             overrun
);
    // a word may enter when the slot is empty or is being emptied this cycle
    logic can_load;
    assign can_load = !vld || rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data    <= '0;
            cout    <= 1'b0;
            vld     <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= load_vld && !can_load;
            if (load_vld && can_load) begin
                data <= load_data;
                cout <= load_cout;
                vld  <= 1'b1;
            end else if (rdy) begin
                vld <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/serial_sum_deser.sv
// serial_sum_deser: assembles LSB-first sum/cout bit streams from serial_adder into parallel words.
// Ports: clk, rst (async, active-high); bit_vld/sof/sum/cout serial input; word_data/word_cout/word_vld/word_rdy
// valid/ready output; busy (word in progress); err_frame and overrun one-cycle error pulses.
// Optional macro SERIAL_SUM_DESER_STATS_EN adds saturating ovr_cnt/frm_cnt pulse counters.
module serial_sum_deser
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_vld,
    input  logic             sof,
    input  logic             sum,
    input  logic             cout,
    output logic [WIDTH-1:0] word_data,
    output logic             word_cout,
    output logic             word_vld,
    input  logic             word_rdy,
    output logic             busy,
    output logic             err_frame,
    output logic             overrun
`ifdef SERIAL_SUM_DESER_STATS_EN
    ,
    output logic [STAT_W-1:0] ovr_cnt,
    output logic [STAT_W-1:0] frm_cnt
`endif
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    deser_state_e     state;
    logic [WIDTH-2:0] sreg;
    logic [CNT_W-1:0] count;
    logic             last;

    // the MSB is never stored: it is taken straight from sum on the final bit
    assign last = (state == SHIFT) && bit_vld && !sof && (count == CNT_W'(WIDTH - 1));
    assign busy = (state == SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sreg      <= '0;
            count     <= '0;
            err_frame <= 1'b0;
        end else begin
            // a framing error is a missing sof in IDLE or an unexpected sof mid-word
            err_frame <= bit_vld && (sof == (state == SHIFT));
            if (bit_vld && sof) begin
                sreg  <= (WIDTH-1)'(sum);
                count <= CNT_W'(1);
                state <= SHIFT;
            end else if (bit_vld && state == SHIFT) begin
                sreg  <= sreg | ((WIDTH-1)'(sum) << count);
                count <= last ? '0 : count + CNT_W'(1);
                state <= last ? IDLE : SHIFT;
            end
        end
    end

    deser_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load_vld  (last),
        .load_data ({sum, sreg}),
        .load_cout (cout),
        .rdy       (word_rdy),
        .data      (word_data),
        .cout      (word_cout),
        .vld       (word_vld),
        .overrun   (overrun)
    );

`ifdef SERIAL_SUM_DESER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_cnt <= '0;
            frm_cnt <= '0;
        end else begin
            ovr_cnt <= ovr_cnt + STAT_W'(overrun && ovr_cnt != '1);
            frm_cnt <= frm_cnt + STAT_W'(err_frame && frm_cnt != '1);
        end
    end
`endif
endmodule
